param_counter: RTL and testbench
================================

Name: param_counter

Overview:
Parametrised successor to the team's 4-bit clear-to-zero counter. Provides:
- configurable width and modulus
- up/down counting with count enable
- synchronous parallel load and synchronous clear
- wrap or saturate mode at the count limits
- terminal-count and wrap-event flags

Used as the general timer/divider primitive across the design, replacing fixed 4-bit ripple counters.

Parameters:
WIDTH, 4, bit width of the count register Q.
MODULUS, 16, number of count states; Q ranges 0..MODULUS-1; legal range 2..2^WIDTH.
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
clock  input  1  rising-edge clock.
clear_n  input  1  asynchronous active-low reset.
sync_clear  input  1  synchronous clear to 0; highest synchronous priority.
load  input  1  synchronous parallel load of load_value.
load_value  input  WIDTH  value to load.
enable  input  1  count enable.
up_down  input  1  count direction: 1 = up, 0 = down.
Q  output  WIDTH  current count, registered.
tc  output  1  terminal count, combinational.
wrapped  output  1  registered one-cycle pulse after a wrap event.

Behaviour:
Reset:
- clear_n low asynchronously forces Q=0 and wrapped=0, independent of clock.
- While clear_n is low, Q holds 0.
- Deassertion is sampled at the next rising edge; the first count occurs on the first edge with clear_n high.

Synchronous priority, each rising edge with clear_n high:
1. sync_clear -> Q=0, wrapped=0.
2. else load -> Q = load_value if load_value <= MODULUS-1, else Q = MODULUS-1 (clamp); wrapped=0.
3. else enable -> count per up_down, as defined below.
4. else hold Q; wrapped=0.

Counting, one step per enabled edge, no latency beyond the register:
- Up, Q < MODULUS-1 -> Q+1.
- Up, Q == MODULUS-1 -> Q=0 and wrapped=1 if SATURATE=0; hold Q, wrapped=0 if SATURATE=1.
- Down, Q > 0 -> Q-1.
- Down, Q == 0 -> Q=MODULUS-1 and wrapped=1 if SATURATE=0; hold 0, wrapped=0 if SATURATE=1.
- Direction change takes effect on the same edge up_down is sampled; no dead cycle.

Flags:
- tc = enable & ((up_down & Q==MODULUS-1) | (~up_down & Q==0)).
- tc is independent of load and sync_clear.
- wrapped is a single-cycle pulse; back-to-back wraps give consecutive pulses (e.g. MODULUS=2 counting continuously).

Arithmetic and structure:
- All compares and increments are done at WIDTH bits; there is no intermediate overflow when MODULUS = 2^WIDTH.
- Q never holds a value >= MODULUS.
- No other state is held; the block has no FSM beyond the count register and the wrapped flop.

Boundary cases:
- Load and enable together: load wins; the loaded value is not incremented on that edge.
- sync_clear and load together: Q=0.
- clear_n asserted mid-count: Q=0 immediately (asynchronous); a wrapped pulse in flight is cancelled.
- enable low: Q stable, tc=0, wrapped=0.

Test Plan:
1. WIDTH=4, MODULUS=10, SATURATE=0; clear_n low 34 time units then high; enable=1, up_down=1 for 12 edges -> Q goes 0,1,...,9,0,1; tc=1 only while Q=9; wrapped=1 for exactly the one cycle after Q 9->0.
2. Same configuration; load=1, load_value=4'd13 -> Q=9 (clamped). Then up_down=0 for 11 edges -> Q goes 8,7,...,0,9; tc=1 while Q=0; wrapped pulses once.
3. SATURATE=1, MODULUS=10; count up from 7 for 5 edges -> Q goes 8,9,9,9,9; wrapped stays 0; tc stays 1 while Q=9. Down from 1 -> Q goes 0,0,0.
4. Priority check: sync_clear=1, load=1, enable=1 with Q=5 -> Q=0. Then load=1, enable=1, load_value=3 -> Q=3, not 4.
5. Async reset: mid-count at Q=6, pull clear_n low between clock edges -> Q=0 before the next edge; wrapped=0. Release clear_n -> Q counts 1 at the first subsequent enabled edge.
6. WIDTH=4, MODULUS=16 and WIDTH=3, MODULUS=2; run continuously up -> MODULUS=16 wraps 15->0 with no X/overflow; MODULUS=2 gives Q alternating 0,1 with wrapped pulsing every second cycle.

Source files
------------

// File: rtl/param_counter.sv
// rtl/param_counter.sv - up/down modulus counter with load, clear, wrap/saturate and flags
module param_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             sync_clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrapped
);

    // MODULUS may equal 2^WIDTH, so the top state is formed in 32-bit int before truncation.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic             SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrapped_q, wrapped_d;
    logic             at_max, at_zero;

    assign at_max  = (q_q == MAX_VAL);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d       = q_q;
        wrapped_d = 1'b0;
        if (sync_clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (!at_max) begin
                    q_d = q_q + WIDTH'(1);
                end else if (!SAT) begin
                    q_d       = '0;
                    wrapped_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_d = q_q - WIDTH'(1);
                end else if (!SAT) begin
                    q_d       = MAX_VAL;
                    wrapped_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            q_q       <= '0;
            wrapped_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign Q       = q_q;
    assign wrapped = wrapped_q;
    assign tc      = enable & ((up_down & at_max) | (~up_down & at_zero));

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - directed vector bench for param_counter in four configurations
module tb_param_counter;

    logic       clock = 1'b0;
    logic       clear_n, sync_clear, load, enable, up_down;
    logic [3:0] load_value;

    logic [3:0] q0, q1, q2;
    logic [2:0] q3;
    logic       tc0, tc1, tc2, tc3, wr0, wr1, wr2, wr3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // 0: mod10 wrap, 1: mod10 saturate, 2: full 4-bit mod16, 3: 3-bit mod2
    param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_m10w (
        .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .Q(q0), .tc(tc0), .wrapped(wr0));
    param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_m10s (
        .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .Q(q1), .tc(tc1), .wrapped(wr1));
    param_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_m16 (
        .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .Q(q2), .tc(tc2), .wrapped(wr2));
    param_counter #(.WIDTH(3), .MODULUS(2), .SATURATE(0)) u_m2 (
        .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear), .load(load),
        .load_value(load_value[2:0]), .enable(enable), .up_down(up_down),
        .Q(q3), .tc(tc3), .wrapped(wr3));

    typedef struct packed {
        logic [1:0] d;
        logic       sc;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       ud;
        logic [3:0] q;
        logic       tc;
        logic       wr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [1:0] d, input logic sc, input logic ld,
                               input logic [3:0] lv, input logic en, input logic ud,
                               input logic [3:0] q, input logic t, input logic w);
        vec_t r;
        r.d = d; r.sc = sc; r.ld = ld; r.lv = lv; r.en = en; r.ud = ud;
        r.q = q; r.tc = t; r.wr = w;
        return r;
    endfunction

    function automatic logic [3:0] q_of(input logic [1:0] d);
        case (d)
            2'd0:    return q0;
            2'd1:    return q1;
            2'd2:    return q2;
            default: return {1'b0, q3};
        endcase
    endfunction

    function automatic logic tc_of(input logic [1:0] d);
        case (d)
            2'd0:    return tc0;
            2'd1:    return tc1;
            2'd2:    return tc2;
            default: return tc3;
        endcase
    endfunction

    function automatic logic wr_of(input logic [1:0] d);
        case (d)
            2'd0:    return wr0;
            2'd1:    return wr1;
            2'd2:    return wr2;
            default: return wr3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic sc, input logic ld, input logic [3:0] lv,
                         input logic en, input logic ud);
        sync_clear = sc; load = ld; load_value = lv; enable = en; up_down = ud;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_dut(input string tag, input logic [1:0] d, input logic [3:0] q,
                             input logic t, input logic w);
        chk($sformatf("%s.q", tag), q_of(d), q);
        chk($sformatf("%s.tc", tag), {3'b0, tc_of(d)}, {3'b0, t});
        chk($sformatf("%s.wrapped", tag), {3'b0, wr_of(d)}, {3'b0, w});
    endtask

    initial begin
        // Up count 1..9 then wrap on mod10
        for (int k = 1; k <= 12; k++)
            tbl.push_back(v(0, 0, 0, 0, 1, 1, 4'(k % 10), (k % 10) == 9, (k % 10) == 0));
        // Load 13 clamps to 9, then count down through the 0 -> 9 wrap
        tbl.push_back(v(0, 0, 1, 13, 1, 1, 9, 1, 0));
        for (int k = 8; k >= 0; k--)
            tbl.push_back(v(0, 0, 0, 0, 1, 0, 4'(k), k == 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 9, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 8, 0, 0));
        // Saturating mod10: up from 7, then down from 1
        tbl.push_back(v(1, 0, 1, 7, 0, 1, 7, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 8, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 9, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 9, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 9, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 9, 1, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 1, 0));
        // Priority, hold, load clamp boundary
        tbl.push_back(v(0, 0, 1, 5, 0, 1, 5, 0, 0));
        tbl.push_back(v(0, 1, 1, 5, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 3, 1, 1, 3, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 3, 0, 0));
        tbl.push_back(v(0, 0, 1, 10, 0, 1, 9, 0, 0));
        tbl.push_back(v(0, 0, 1, 9, 1, 1, 9, 1, 0));

        clear_n = 1'b0;
        drive(0, 0, 0, 1, 1);
        #34;
        check_dut("reset_m10", 0, 0, 0, 0);
        check_dut("reset_m2", 3, 0, 0, 0);
        clear_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].sc, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].ud);
            tick();
            check_dut($sformatf("vec%0d", i), tbl[i].d, tbl[i].q, tbl[i].tc, tbl[i].wr);
        end

        // Async clear mid-count also cancels a wrapped pulse already on the output
        drive(0, 1, 5, 0, 1);
        tick();
        drive(0, 0, 0, 1, 1);
        tick();
        chk("async_pre.q", q0, 6);
        chk("async_pre.m2_wrapped", {3'b0, wr3}, 1);
        #3 clear_n = 1'b0;
        #1;
        chk("async.q", q0, 0);
        chk("async.wrapped", {3'b0, wr0}, 0);
        chk("async.m2_wrapped", {3'b0, wr3}, 0);
        #2 clear_n = 1'b1;
        tick();
        chk("async_release.q", q0, 1);

        // Full-range mod16 wrap and back-to-back mod2 wraps
        drive(0, 1, 8, 0, 1);
        tick();
        chk("m16_load.q", q2, 8);
        chk("m2_load.q", {1'b0, q3}, 0);
        drive(0, 0, 0, 1, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_dut($sformatf("m16_up%0d", k), 2, 4'((8 + k) % 16),
                      ((8 + k) % 16) == 15, ((8 + k) % 16) == 0);
            check_dut($sformatf("m2_up%0d", k), 3, 4'(k % 2), (k % 2) == 1, (k % 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
